bcd2bin_seq: RTL and testbench
==============================

// Module: bcd2bin_seq
// PURPOSE
//   Sequential BCD-to-binary converter using reverse double-dabble (shift right, then subtract 3
//   from each nibble >= 8). It is the inverse of the combinational bin2bcd path. It turns
//   digit-entry values (per-digit BCD from buttons/switches) back into a binary counter value.
//   Start/done handshake; one iteration per clock; sits between the digit editor and counter logic.
// PARAMETERS
//   DIGITS  4   number of BCD digits on input (>= 1)
//   W       14  binary output width; must satisfy 2**W > 10**DIGITS - 1 (14 for 4 digits)
// PORTS
//   clk    in   1         system clock; all state on posedge clk
//   rst_n  in   1         asynchronous, active-low reset
//   start  in   1         request conversion of bcd; sampled only in IDLE or DONE
//   bcd    in   4*DIGITS  packed digits, digit 0 in [3:0]; sampled on the accepting edge only
//   busy   out  1         high while conversion iterations run
//   done   out  1         one-cycle pulse: bin/err valid
//   bin    out  W         result; holds last value until the next completion
//   err    out  1         invalid digit (>9) seen; valid with done, held like bin
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE, busy=0, done=0, bin=0, err=0, shift reg=0, count=0.
//     Release is synchronous to clk. Reset mid-run aborts with no done pulse.
//   - FSM states: IDLE, RUN, DONE.
//     IDLE --start--> RUN; RUN --count==W-1--> DONE; DONE --start--> RUN, else --> IDLE.
//   - Accept edge (start=1 in IDLE/DONE): load reg = {bcd, W'b0} (4*DIGITS+W bits), count=0.
//     busy=1 in the cycle after.
//   - RUN, each edge: reg = reg >> 1, then every BCD nibble of reg >= 8 gets -3 (4-bit, no borrow
//     across nibbles); count++.
//   - After W RUN edges: bin <= reg[W-1:0], err <= 0, state=DONE.
//     done=1 and busy=0 for exactly one cycle.
//   - Latency: accept edge at k, done visible after edge k+W. busy high W cycles.
//     Back-to-back start in the DONE cycle gives a result every W+1 cycles.
//   - start while busy: ignored, no queueing; the in-flight result is unaffected.
//   - Inputs 0 and all-9s are legal boundaries. All-9s gives 10**DIGITS-1 with no overflow,
//     given the W constraint.
//   - bcd may change freely after the accept edge.
// CONFIGURATION
//   BCD2BIN_CHECK_EN defined: on the accept edge, if any nibble > 9, skip RUN.
//     Next state is DONE with bin <= 0 and err <= 1, so done appears 1 cycle after accept.
//   BCD2BIN_CHECK_EN undefined: no check. err is tied 0.
//     Invalid digits run the normal W iterations; the result is deterministic but unspecified.
// STRUCTURE
//   Package bcd_pkg:
//     typedef logic [3:0] bcd_digit_t;
//     typedef enum logic [1:0] {IDLE, RUN, DONE} b2b_state_t;
//     function is_bcd_digit(bcd_digit_t d) (d <= 9).
//   Sub-module bcd_digit_adj:
//     one nibble, combinational: out = (in >= 8) ? in - 3 : in.
//     Instantiated DIGITS times in a generate loop on the post-shift register.
//   Parameter check: elaboration-time $error if 2**W <= 10**DIGITS - 1.
// TESTING  (DIGITS=4, W=14)
//   1. bcd=16'h9999, start pulse -> after 14 edges done=1 one cycle, bin=14'd9999 (0x270F), err=0.
//   2. bcd=16'h0000 -> bin=0, done once; then bcd=16'h1234 -> bin=1234 (0x04D2).
//   3. start held high continuously with bcd=16'h0042 -> done every 15 cycles, bin=42 each time.
//   4. start again at cycle 5 of a run with bcd changed to 16'h0001 -> ignored;
//      result = original value at cycle 14.
//   5. rst_n=0 at cycle 7 of a run -> busy=done=bin=err=0 immediately, FSM IDLE, no done pulse.
//   6. CHECK_EN, bcd=16'h12A4 -> done 1 cycle after accept, err=1, bin=0.
//      Without CHECK_EN, err stays 0 and done arrives at 14 edges.
//   Also: random sweep 0..9999, bin2bcd(bin) must equal the applied bcd.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD/binary conversion blocks.
package bcd_pkg;

   typedef logic [3:0] bcd_digit_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } b2b_state_t;

   function automatic logic is_bcd_digit(bcd_digit_t d);
      return (d <= 4'd9);
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One-nibble correction step of reverse double-dabble: subtract 3 from digits >= 8.
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  bcd_digit_t raw,
   input  logic       unused_tie,
   output bcd_digit_t adj
);

   assign adj = (raw >= 4'd8) ? raw - 4'd3 : raw;

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter, one reverse double-dabble iteration per clock.
// Optional digit validity check enabled by defining BCD2BIN_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | shift/correct iterations in progress (busy)
// DONE  | one-cycle result strobe; start here chains the next conversion
module bcd2bin_seq
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4,
   parameter int W      = 14
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [4*DIGITS-1:0] bcd,
   output logic                busy,
   output logic                done,
   output logic [W-1:0]        bin,
   output logic                err
);

   localparam int BW = 4 * DIGITS;
   localparam int RW = BW + W;
   localparam int CW = $clog2(W);

   if ((2 ** W) <= (10 ** DIGITS - 1)) begin : g_width_check
      $error("bcd2bin_seq: W too small to hold 10**DIGITS-1");
   end

   b2b_state_t    state, state_nxt;
   logic [RW-1:0] sr, sr_shift, sr_adj;
   logic [CW-1:0] count;
   logic          accept, last, bad;

   assign sr_shift       = sr >> 1;
   assign sr_adj[W-1:0]  = sr_shift[W-1:0];

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .raw        (sr_shift[W+4*g +: 4]),
         .unused_tie (1'b0),
         .adj        (sr_adj[W+4*g +: 4])
      );
   end

`ifdef BCD2BIN_CHECK_EN
   always_comb begin
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (!is_bcd_digit(bcd[4*i +: 4])) bad = 1'b1;
      end
   end
`else
   assign bad = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      last      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = bad ? DONE : RUN;
            end
         end
         RUN: begin
            if (count == CW'(W - 1)) begin
               last      = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = bad ? DONE : RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr    <= '0;
         count <= '0;
         bin   <= '0;
      end else if (accept) begin
         sr    <= {bcd, {W{1'b0}}};
         count <= '0;
         if (bad) bin <= '0;
      end else if (state == RUN) begin
         sr    <= sr_adj;
         count <= count + CW'(1);
         if (last) bin <= sr_adj[W-1:0];
      end
   end

`ifdef BCD2BIN_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               err <= 1'b0;
      else if (accept && bad)   err <= 1'b1;
      else if (last)            err <= 1'b0;
   end
`else
   assign err = 1'b0;
`endif

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed and swept checks of bcd2bin_seq with DIGITS=4, W=14.
module tb_bcd2bin_seq;

   localparam int DIGITS = 4;
   localparam int W      = 14;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [15:0]   bcd;
   logic          busy;
   logic          done;
   logic [W-1:0]  bin;
   logic          err;

   int n_cmp = 0;
   int n_bad = 0;

   bcd2bin_seq #(.DIGITS(DIGITS), .W(W)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .bcd   (bcd),
      .busy  (busy),
      .done  (done),
      .bin   (bin),
      .err   (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      r[3:0]   = 4'(v % 10);
      r[7:4]   = 4'((v / 10) % 10);
      r[11:8]  = 4'((v / 100) % 10);
      r[15:12] = 4'((v / 1000) % 10);
      return r;
   endfunction

   // Drive one conversion; called with time just after a posedge.
   // poke >= 0 re-asserts start with a different bcd that many edges after accept.
   task automatic run_conv(input string tag, input logic [15:0] b, input int exp_bin,
                           input logic chk_bin, input int exp_lat, input int exp_err,
                           input int poke);
      int lat;
      int busy_n;
      start = 1'b1;
      bcd   = b;
      @(posedge clk); #1;
      start  = 1'b0;
      bcd    = 16'h5555;
      lat    = 0;
      busy_n = 0;
      while (!done && lat < 40) begin
         if (busy) busy_n++;
         @(posedge clk);
         #1;
         lat++;
         if (lat == poke) begin
            start = 1'b1;
            bcd   = 16'h0001;
         end else begin
            start = 1'b0;
         end
      end
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_busy"}, busy_n, exp_lat);
      chk({tag, "_done"}, int'(done), 1);
      if (chk_bin) chk({tag, "_bin"}, int'(bin), exp_bin);
      chk({tag, "_err"}, int'(err), exp_err);
      @(posedge clk); #1;
      chk({tag, "_pulse"}, int'(done), 0);
   endtask

   initial begin
      int t_done[3];
      int nd;
      int v;

      rst_n = 1'b0;
      start = 1'b0;
      bcd   = 16'h0000;
      #2;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_bin",  int'(bin), 0);
      chk("rst_err",  int'(err), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_conv("nines", 16'h9999, 9999, 1'b1, W, 0, -1);
      run_conv("zero",  16'h0000, 0,    1'b1, W, 0, -1);
      run_conv("n1234", 16'h1234, 1234, 1'b1, W, 0, -1);

      // start held high: chained conversions every W+1 cycles
      start = 1'b1;
      bcd   = 16'h0042;
      @(posedge clk); #1;
      nd = 0;
      for (int c = 1; c <= 60 && nd < 3; c++) begin
         @(posedge clk); #1;
         if (done) begin
            t_done[nd] = c;
            chk($sformatf("held_bin%0d", nd), int'(bin), 42);
            nd++;
         end
      end
      start = 1'b0;
      chk("held_count", nd, 3);
      if (nd == 3) begin
         chk("held_t0", t_done[0], W);
         chk("held_t1", t_done[1], 2 * W + 1);
         chk("held_t2", t_done[2], 3 * W + 2);
      end
      repeat (3) @(posedge clk);
      #1;

      run_conv("ignore", 16'h0867, 867, 1'b1, W, 0, 5);

      // reset in mid-run clears everything at once and suppresses done
      start = 1'b1;
      bcd   = 16'h0777;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      chk("midrst_busy_before", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_bin",  int'(bin), 0);
      chk("midrst_err",  int'(err), 0);
      @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (done || busy) nd++;
      end
      chk("midrst_quiet", nd, 0);

`ifdef BCD2BIN_CHECK_EN
      run_conv("invalid", 16'h12A4, 0, 1'b1, 0, 1, -1);
      run_conv("after_inv", 16'h0500, 500, 1'b1, W, 0, -1);
`else
      run_conv("invalid", 16'h12A4, 0, 1'b0, W, 0, -1);
`endif

      for (int i = 0; i < 20; i++) begin
         v = (i == 0) ? 1 : ((i == 1) ? 9990 : int'($urandom_range(0, 9999)));
         run_conv($sformatf("sweep%0d", v), to_bcd(v), v, 1'b1, W, 0, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
